msp430_noc_echo_endpoint: RTL and testbench

MSP430_NOC_ECHO_ENDPOINT -- requirements
Module: msp430_noc_echo_endpoint

---
 rtl/msp430_noc_pkg.sv | 20 ++
 rtl/msp430_noc_pkt_buffer.sv | 28 ++
 rtl/msp430_noc_echo_endpoint.sv | 176 +++++++++++++++++
 tb/tb_msp430_noc_echo_endpoint.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msp430_noc_pkg.sv
// Shared definitions for the NoC echo endpoint.
// Holds the header flit field positions and the endpoint FSM state encoding.
package msp430_noc_pkg;

  localparam int DEST_HI    = 31;
  localparam int DEST_LO    = 27;
  localparam int CLASS_HI   = 26;
  localparam int CLASS_LO   = 24;
  localparam int SRC_HI     = 23;
  localparam int SRC_LO     = 19;
  localparam int PAYLOAD_HI = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_SEND,
    ST_DROP
  } noc_state_e;

endpackage

// File: rtl/msp430_noc_pkt_buffer.sv
// Packet storage for the echo endpoint.
// Ports:
//   clk            - write clock (rising edge)
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - asynchronous read port
// Contents are intentionally not reset.
module msp430_noc_pkt_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [FLIT_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [FLIT_WIDTH-1:0] rdata
);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/msp430_noc_echo_endpoint.sv
// NoC echo endpoint: receives a request packet, buffers it and sends it back
// to the requester with the header rewritten (dest=old src, src=ID).
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   enable                         - permits acceptance of a new header
//   in_flit/in_last/in_valid/in_ready      - request channel
//   out_flit/out_last/out_valid/out_ready  - reply channel
//   pkt_count                      - completed replies (wrapping)
//   overflow                       - sticky: an oversize packet was dropped
//
// state | meaning
// IDLE  | waiting for a header (in_ready follows enable)
// RECV  | storing body flits until in_last
// SEND  | replaying the buffer on the reply channel
// DROP  | discarding the rest of an oversize packet
module msp430_noc_echo_endpoint
  import msp430_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int ID         = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           pkt_count,
  output logic                  overflow
);

  localparam int           AW      = $clog2(MAX_LEN);
  localparam logic [AW:0]  FULL    = (AW+1)'(MAX_LEN);
  localparam logic [4:0]   ID_BITS = 5'(ID);

  noc_state_e            state, state_nx;
  logic [AW:0]           wr_cnt, wr_cnt_nx;
  logic [AW:0]           len, len_nx;
  logic [AW-1:0]         rd_ptr, rd_ptr_nx;
  logic [15:0]           pkt_count_nx;
  logic                  overflow_nx;
  // Holds in_ready low while reset is asserted even though IDLE follows enable.
  logic                  active;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [FLIT_WIDTH-1:0] wdata, rd_data;
  logic                  in_hs, out_hs, rd_last;

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign rd_last = ({1'b0, rd_ptr} == (len - 1'b1));

  msp430_noc_pkt_buffer #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (MAX_LEN),
    .AW         (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      len       <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
      overflow  <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_cnt    <= wr_cnt_nx;
      len       <= len_nx;
      rd_ptr    <= rd_ptr_nx;
      pkt_count <= pkt_count_nx;
      overflow  <= overflow_nx;
      active    <= 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    wr_cnt_nx    = wr_cnt;
    len_nx       = len;
    rd_ptr_nx    = rd_ptr;
    pkt_count_nx = pkt_count;
    overflow_nx  = overflow;
    we           = 1'b0;
    waddr        = wr_cnt[AW-1:0];
    wdata        = in_flit;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_flit     = '0;

    case (state)
      ST_IDLE: begin
        in_ready = enable & active;
        if (in_hs) begin
          // The reply header is built on the way in so SEND is a plain replay.
          we    = 1'b1;
          waddr = '0;
          wdata[DEST_HI:DEST_LO]   = in_flit[SRC_HI:SRC_LO];
          wdata[CLASS_HI:CLASS_LO] = in_flit[CLASS_HI:CLASS_LO];
          wdata[SRC_HI:SRC_LO]     = ID_BITS;
          wdata[PAYLOAD_HI:0]      = in_flit[PAYLOAD_HI:0];
          wr_cnt_nx = (AW+1)'(1);
          if (in_last) begin
            len_nx   = (AW+1)'(1);
            state_nx = ST_SEND;
          end else begin
            state_nx = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        in_ready = 1'b1;
        if (in_hs) begin
          if (wr_cnt == FULL) begin
            // Flit MAX_LEN+1: packet is oversize whether or not it ends here.
            wr_cnt_nx = '0;
            if (in_last) begin
              overflow_nx = 1'b1;
              state_nx    = ST_IDLE;
            end else begin
              state_nx = ST_DROP;
            end
          end else begin
            we        = 1'b1;
            wr_cnt_nx = wr_cnt + 1'b1;
            if (in_last) begin
              len_nx   = wr_cnt + 1'b1;
              state_nx = ST_SEND;
            end
          end
        end
      end
      ST_DROP: begin
        in_ready = 1'b1;
        if (in_hs && in_last) begin
          overflow_nx = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_flit  = rd_data;
        out_last  = rd_last;
        if (out_hs) begin
          if (rd_last) begin
            pkt_count_nx = pkt_count + 16'd1;
            rd_ptr_nx    = '0;
            wr_cnt_nx    = '0;
            len_nx       = '0;
            state_nx     = ST_IDLE;
          end else begin
            rd_ptr_nx = rd_ptr + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_msp430_noc_echo_endpoint.sv
// Self-checking bench for msp430_noc_echo_endpoint (default parameters).
module tb_msp430_noc_echo_endpoint;

  typedef logic [31:0] flit_q_t[$];

  localparam int ID      = 1;
  localparam int MAX_LEN = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] in_flit;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_flit;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic        overflow;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count = '0;
  logic        exp_ovf   = 1'b0;

  always #5 clk = ~clk;

  msp430_noc_echo_endpoint #(
    .FLIT_WIDTH (32),
    .MAX_LEN    (MAX_LEN),
    .ID         (ID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_count (pkt_count),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Reply model straight from the header layout: dest <- src, src <- ID,
  // class and payload kept, body untouched.
  function automatic flit_q_t make_reply(input flit_q_t req);
    flit_q_t     r;
    logic [31:0] h;
    logic [31:0] src;
    r   = req;
    h   = req[0];
    src = (h >> 19) & 32'd31;
    r[0] = (src << 27) | (32'(ID) << 19) | (h & 32'h0707_FFFF);
    return r;
  endfunction

  // Entered and left near a negedge.
  task automatic push_flit(input logic [31:0] f, input logic l);
    int cyc = 0;
    bit r   = 1'b0;
    in_flit  = f;
    in_last  = l;
    in_valid = 1'b1;
    while (!r && cyc < 60) begin
      #1 r = in_ready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (!r) check("in_hs_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // mode: 0 random out_ready, 1 toggling, 2 always ready
  task automatic collect(input flit_q_t exp, input int mode);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (idx < exp.size() && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       begin out_ready = tog; tog = !tog; end
        default: out_ready = 1'b1;
      endcase
      #1;
      check("out_valid_in_send", 32'(out_valid), 32'd1);
      if (out_valid) begin
        check("out_flit", out_flit, exp[idx]);
        check("out_last", 32'(out_last), 32'(idx == exp.size() - 1));
        if (out_ready) idx++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < exp.size()) check("collect_timeout", 32'(idx), 32'(exp.size()));
    #1 check("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic run_packet(input flit_q_t pkt, input int mode, input bit drop_en);
    for (int i = 0; i < pkt.size(); i++) begin
      gap();
      push_flit(pkt[i], 1'(i == pkt.size() - 1));
      if (i == 0 && drop_en) enable = 1'b0;
    end
    if (pkt.size() <= MAX_LEN) begin
      collect(make_reply(pkt), mode);
      exp_count = exp_count + 16'd1;
    end else begin
      exp_ovf = 1'b1;
      repeat (3) begin
        #1 check("no_reply", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
      end
    end
    #1;
    check("pkt_count", 32'(pkt_count), 32'(exp_count));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    enable = 1'b1;
  endtask

  function automatic flit_q_t rand_pkt(input int len);
    flit_q_t q;
    for (int i = 0; i < len; i++) q.push_back($urandom);
    return q;
  endfunction

  task automatic do_reset_checks();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_flit", out_flit, 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    flit_q_t p;
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_flit   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    do_reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic 3-flit echo
    p = '{32'h0A00_1234, 32'hDEAD_0001, 32'hBEEF_0002};
    run_packet(p, 0, 1'b0);

    // single-flit packet, reply starts the cycle after the handshake
    p = '{32'h1388_0000};
    run_packet(p, 2, 1'b0);

    // stalling reply channel
    p = rand_pkt(6);
    run_packet(p, 1, 1'b0);

    // oversize packets: exactly one and two flits over
    p = rand_pkt(MAX_LEN + 1);
    run_packet(p, 2, 1'b0);
    p = rand_pkt(2);
    run_packet(p, 0, 1'b0);
    p = rand_pkt(MAX_LEN + 2);
    run_packet(p, 2, 1'b0);

    // exactly full buffer
    p = rand_pkt(MAX_LEN);
    run_packet(p, 0, 1'b0);

    // header held while disabled is not taken
    enable   = 1'b0;
    in_flit  = 32'h5555_AAAA;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (4) begin
      #1 check("disabled_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    #1 check("disabled_no_send", 32'(out_valid), 32'd0);
    @(negedge clk);

    // enable dropped after the header does not stop the packet
    p = rand_pkt(4);
    run_packet(p, 0, 1'b1);

    // reset in the middle of a packet
    p = rand_pkt(5);
    push_flit(p[0], 1'b0);
    push_flit(p[1], 1'b0);
    rst_n = 1'b0;
    #1;
    do_reset_checks();
    exp_count = '0;
    exp_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    p = rand_pkt(3);
    run_packet(p, 0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      p = rand_pkt($urandom_range(1, MAX_LEN + 2));
      run_packet(p, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
